// File: rtl/sgdmac_read_mb.sv
// SG-DMA read engine: splits a source buffer into 4 KB-safe AXI3 INCR bursts,
// gates each request on FIFO space and streams read data into the data FIFO.
module sgdmac_read_mb #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [3:0]                      arid_o,
  output logic [31:0]                     araddr_o,
  output logic [3:0]                      arlen_o,
  output logic [2:0]                      arsize_o,
  output logic [1:0]                      arburst_o,
  output logic                            arvalid_o,
  input  logic                            arready_i,
  input  logic [3:0]                      rid_i,
  input  logic [DATA_W-1:0]               rdata_i,
  input  logic [1:0]                      rresp_i,
  input  logic                            rlast_i,
  input  logic                            rvalid_i,
  output logic                            rready_o,
  input  logic                            start_i,
  input  logic [47:0]                     cmd_i,
  output logic                            done_o,
  output logic                            err_o,
  input  logic                            fifo_afull_i,
  input  logic [$clog2(FIFO_DEPTH):0]     fifo_free_i,
  output logic                            fifo_wren_o,
  output logic [DATA_W-1:0]               fifo_wdata_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SZ    = $clog2(BYTES);
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA} state_t;

  state_t             state, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        remain_q, remain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [31:0]        araddr_d;
  logic [3:0]         arlen_d;

  logic [15:0]        cmd_beats;
  logic [16:0]        to_bound;
  logic [16:0]        beats_w;
  logic [CNT_W-1:0]   beats;
  logic [CNT_W-1:0]   ar_beats;
  logic               hs;
  logic               beat_err;

  assign cmd_beats = cmd_i[15:0] >> SZ;
  assign to_bound  = 17'((13'd4096 - {1'b0, addr_q[11:0]}) >> SZ);
  assign ar_beats  = CNT_W'(arlen_o) + CNT_W'(1);
  assign hs        = (state == S_DATA) && rvalid_i && !fifo_afull_i;
  assign beat_err  = (rresp_i != 2'b00) || (rid_i != 4'(AXI_ID)) ||
                     (rlast_i && cnt_q != CNT_W'(1)) || (!rlast_i && cnt_q == CNT_W'(1));

  // Burst length: min of remaining beats, max burst and beats left in the 4 KB page
  always_comb begin
    beats_w = {1'b0, remain_q};
    if (17'(MAX_BURST) < beats_w) beats_w = 17'(MAX_BURST);
    if (to_bound < beats_w)       beats_w = to_bound;
    beats = CNT_W'(beats_w);
  end

  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    araddr_d = araddr_o;
    arlen_d  = arlen_o;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          err_d    = 1'b0;
          addr_d   = cmd_i[47:16] & ~32'(BYTES - 1);
          remain_d = cmd_beats;
          if (cmd_beats != 16'd0) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        araddr_d = addr_q;
        arlen_d  = 4'(beats - CNT_W'(1));
        if (17'(fifo_free_i) >= beats_w) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (arready_i) begin
          addr_d   = addr_q + (32'(ar_beats) << SZ);
          remain_d = remain_q - 16'(ar_beats);
          cnt_d    = ar_beats;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (beat_err) err_d = 1'b1;
          // A failed burst is drained to RLAST, then the rest of the buffer is abandoned
          if (rlast_i)
            state_d = (err_q || beat_err || remain_q == 16'd0) ? S_IDLE : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      araddr_o <= '0;
      arlen_o  <= '0;
    end else begin
      state    <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      araddr_o <= araddr_d;
      arlen_o  <= arlen_d;
    end
  end

  assign arid_o       = 4'(AXI_ID);
  assign arsize_o     = 3'(SZ);
  assign arburst_o    = 2'b01;
  assign arvalid_o    = (state == S_ADDR);
  assign rready_o     = (state == S_DATA) && !fifo_afull_i;
  assign done_o       = (state == S_IDLE);
  assign err_o        = err_q;
  assign fifo_wren_o  = hs;
  assign fifo_wdata_o = rdata_i;

endmodule

// File: tb/tb_sgdmac_read_mb.sv
// Scoreboard bench for sgdmac_read_mb: expected AR requests and FIFO writes are
// queued by the stimulus and popped by independent monitors.
module tb_sgdmac_read_mb;
  localparam int unsigned DATA_W = 64;

  logic              clk, rst_n;
  logic [3:0]        arid_o, arlen_o;
  logic [31:0]       araddr_o;
  logic [2:0]        arsize_o;
  logic [1:0]        arburst_o;
  logic              arvalid_o, arready_i;
  logic [3:0]        rid_i;
  logic [DATA_W-1:0] rdata_i;
  logic [1:0]        rresp_i;
  logic              rlast_i, rvalid_i, rready_o;
  logic              start_i;
  logic [47:0]       cmd_i;
  logic              done_o, err_o;
  logic              fifo_afull_i;
  logic [6:0]        fifo_free_i;
  logic              fifo_wren_o;
  logic [DATA_W-1:0] fifo_wdata_o;

  sgdmac_read_mb dut (
    .clk(clk), .rst_n(rst_n),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .start_i(start_i), .cmd_i(cmd_i), .done_o(done_o), .err_o(err_o),
    .fifo_afull_i(fifo_afull_i), .fifo_free_i(fifo_free_i),
    .fifo_wren_o(fifo_wren_o), .fifo_wdata_o(fifo_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [35:0] exp_ar[$];
  logic [63:0] exp_data[$];
  logic [35:0] r_bursts[$];

  int       ar_delay        = 0;
  int       bad_resp_beat   = -1;
  int       early_last_beat = -1;
  logic [3:0] rid_val       = 4'd0;
  bit       kill            = 1'b0;
  bit       afull_en        = 1'b0;
  int       ar_seen         = 0;
  int       wr_cnt          = 0;

  function automatic logic [63:0] word_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // AR slave: holds arready low for ar_delay cycles, checks request stability and content
  initial begin
    int wcnt = 0;
    int hold = 0;
    logic nxt;
    logic [35:0] first;
    arready_i = 1'b0;
    forever begin
      @(negedge clk);
      nxt = 1'b0;
      if (arvalid_o) begin
        if (hold == 0) first = {araddr_o, arlen_o};
        hold++;
        ar_seen++;
        if (arready_i) begin
          check("ar_stable", 64'({araddr_o, arlen_o}), 64'(first));
          check("ar_hold_cycles", 64'(hold), 64'(ar_delay + 2));
          if (exp_ar.size() == 0) begin
            n_checks++;
            $display("FAIL ar_unexpected: got addr 0x%0h len %0d, no request expected", araddr_o, arlen_o);
          end else begin
            check("ar_req", 64'({araddr_o, arlen_o}), 64'(exp_ar.pop_front()));
          end
          r_bursts.push_back({araddr_o, arlen_o});
          hold = 0;
          wcnt = 0;
        end else if (wcnt >= ar_delay) begin
          nxt = 1'b1;
        end else begin
          wcnt++;
        end
      end
      @(posedge clk);
      #1 arready_i = nxt;
    end
  end

  // R slave: streams each accepted burst, with optional error injection knobs
  initial begin
    bit active = 1'b0;
    bit hs_now;
    int beat = 0;
    logic [31:0] baddr = '0;
    logic [3:0]  blen = '0;
    logic [35:0] b;
    rvalid_i = 1'b0; rlast_i = 1'b0; rdata_i = '0; rresp_i = 2'b00; rid_i = 4'd0;
    forever begin
      @(negedge clk);
      hs_now = rvalid_i && rready_o;
      @(posedge clk);
      #1;
      if (kill) begin
        active = 1'b0;
        r_bursts.delete();
      end else begin
        if (hs_now) begin
          if (rlast_i) active = 1'b0;
          else beat++;
        end
        if (!active && r_bursts.size() > 0) begin
          b = r_bursts.pop_front();
          baddr = b[35:4];
          blen = b[3:0];
          beat = 0;
          active = 1'b1;
        end
      end
      if (active) begin
        rvalid_i = 1'b1;
        rdata_i  = word_of(baddr + 32'(beat * 8));
        rresp_i  = (beat == bad_resp_beat) ? 2'b10 : 2'b00;
        rid_i    = rid_val;
        rlast_i  = (beat == int'(blen)) || (beat == early_last_beat);
      end else begin
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        rresp_i  = 2'b00;
      end
    end
  end

  initial begin
    fifo_afull_i = 1'b0;
    forever begin
      @(posedge clk);
      #1 fifo_afull_i = afull_en && ($urandom_range(0, 2) == 0);
    end
  end

  // FIFO write monitor
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_wren_o) begin
        wr_cnt++;
        if (exp_data.size() == 0) begin
          n_checks++;
          $display("FAIL wr_unexpected: got data 0x%0h, no write expected", fifo_wdata_o);
        end else begin
          check("fifo_wdata", 64'(fifo_wdata_o), exp_data.pop_front());
        end
      end
    end
  end

  task automatic start_cmd(input logic [31:0] a, input logic [15:0] c);
    @(posedge clk);
    #1 start_i = 1'b1; cmd_i = {a, c};
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!done_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 64'(done_o), 64'(1));
  endtask

  task automatic push_words(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_data.push_back(word_of(a + 32'(i * 8)));
  endtask

  task automatic end_check(input string name, input logic exp_err);
    check({name, "_ar_left"}, 64'(exp_ar.size()), 64'(0));
    check({name, "_wr_left"}, 64'(exp_data.size()), 64'(0));
    check({name, "_err"}, 64'(err_o), 64'(exp_err));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_done"},    64'(done_o),      64'(1));
    check({name, "_arvalid"}, 64'(arvalid_o),   64'(0));
    check({name, "_rready"},  64'(rready_o),    64'(0));
    check({name, "_wren"},    64'(fifo_wren_o), 64'(0));
    check({name, "_err"},     64'(err_o),       64'(0));
    check({name, "_araddr"},  64'(araddr_o),    64'(0));
    check({name, "_arlen"},   64'(arlen_o),     64'(0));
  endtask

  initial begin
    int seen0;
    int w0;
    int n;
    rst_n = 1'b0; start_i = 1'b0; cmd_i = '0; fifo_free_i = 7'd64;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("arsize", 64'(arsize_o), 64'(3));
    check("arburst", 64'(arburst_o), 64'(1));
    check("arid", 64'(arid_o), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 256 bytes at 0x1000: two full 16-beat bursts, with FIFO backpressure
    afull_en = 1'b1;
    exp_ar.push_back({32'h1000, 4'd15});
    exp_ar.push_back({32'h1080, 4'd15});
    push_words(32'h1000, 32);
    start_cmd(32'h1000, 16'd256);
    wait_done("t1");
    end_check("t1", 1'b0);
    afull_en = 1'b0;

    // 4 KB crossing split
    exp_ar.push_back({32'h1FC0, 4'd7});
    exp_ar.push_back({32'h2000, 4'd7});
    push_words(32'h1FC0, 16);
    start_cmd(32'h1FC0, 16'd128);
    wait_done("t2");
    end_check("t2", 1'b0);

    // short transfer and low-bit truncation
    exp_ar.push_back({32'h0, 4'd4});
    push_words(32'h0, 5);
    start_cmd(32'h0, 16'd40);
    wait_done("t3");
    end_check("t3", 1'b0);
    exp_ar.push_back({32'h0, 4'd1});
    push_words(32'h0, 2);
    start_cmd(32'h4, 16'd20);
    wait_done("t3b");
    end_check("t3b", 1'b0);

    // FIFO space gating, then a slow arready with stable request
    fifo_free_i = 7'd8;
    exp_ar.push_back({32'h3000, 4'd15});
    push_words(32'h3000, 16);
    start_cmd(32'h3000, 16'd128);
    seen0 = ar_seen;
    repeat (20) @(negedge clk);
    check("t4_no_arvalid", 64'(ar_seen - seen0), 64'(0));
    ar_delay = 5;
    @(posedge clk);
    #1 fifo_free_i = 7'd16;
    wait_done("t4");
    end_check("t4", 1'b0);
    ar_delay = 0;
    fifo_free_i = 7'd64;

    // RRESP error on beat 3: burst drained, second burst abandoned
    bad_resp_beat = 2;
    exp_ar.push_back({32'h4000, 4'd15});
    push_words(32'h4000, 16);
    start_cmd(32'h4000, 16'd256);
    wait_done("t5");
    end_check("t5", 1'b1);
    bad_resp_beat = -1;
    start_cmd(32'h0, 16'd4);
    @(negedge clk);
    check("t5_err_cleared", 64'(err_o), 64'(0));
    check("t5_zero_idle", 64'(done_o), 64'(1));

    // early RLAST on beat 10
    early_last_beat = 9;
    exp_ar.push_back({32'h5000, 4'd15});
    push_words(32'h5000, 10);
    start_cmd(32'h5000, 16'd128);
    wait_done("t6");
    end_check("t6", 1'b1);
    early_last_beat = -1;

    // wrong RID
    rid_val = 4'd3;
    exp_ar.push_back({32'h6000, 4'd7});
    push_words(32'h6000, 8);
    start_cmd(32'h6000, 16'd64);
    wait_done("t7");
    end_check("t7", 1'b1);
    rid_val = 4'd0;

    // reset in the middle of a data burst
    exp_ar.push_back({32'h7000, 4'd15});
    push_words(32'h7000, 16);
    start_cmd(32'h7000, 16'd128);
    w0 = wr_cnt;
    n = 0;
    while (wr_cnt < w0 + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t8_writes_started", 64'(wr_cnt >= w0 + 4), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b0; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t8_midreset");
    exp_data.delete();
    exp_ar.delete();
    @(posedge clk);
    #1 rst_n = 1'b1; kill = 1'b0;

    // recovery after reset
    exp_ar.push_back({32'h8000, 4'd7});
    push_words(32'h8000, 8);
    start_cmd(32'h8000, 16'd64);
    wait_done("t9");
    end_check("t9", 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
